// File: rtl/avalon_st_gen_if.sv
// Avalon-MM CSR port and 64-bit Avalon-ST TX port of the packet generator.
// Modport master is the generator view; slave is the host/sink view.
interface avalon_st_gen_if;
  logic [9:0]  avalon_mm_address;
  logic        avalon_mm_write;
  logic        avalon_mm_read;
  logic [31:0] avalon_mm_writedata;
  logic [31:0] avalon_mm_readdata;
  logic        avalon_mm_waitrequest;

  logic [63:0] avalon_st_tx_data;
  logic        avalon_st_tx_valid;
  logic        avalon_st_tx_sop;
  logic        avalon_st_tx_eop;
  logic [2:0]  avalon_st_tx_empty;
  logic        avalon_st_tx_error;
  logic        avalon_st_tx_ready;

  modport master (
    input  avalon_mm_address, avalon_mm_write, avalon_mm_read, avalon_mm_writedata,
    output avalon_mm_readdata, avalon_mm_waitrequest,
    output avalon_st_tx_data, avalon_st_tx_valid, avalon_st_tx_sop, avalon_st_tx_eop,
    output avalon_st_tx_empty, avalon_st_tx_error,
    input  avalon_st_tx_ready
  );

  modport slave (
    output avalon_mm_address, avalon_mm_write, avalon_mm_read, avalon_mm_writedata,
    input  avalon_mm_readdata, avalon_mm_waitrequest,
    input  avalon_st_tx_data, avalon_st_tx_valid, avalon_st_tx_sop, avalon_st_tx_eop,
    input  avalon_st_tx_empty, avalon_st_tx_error,
    output avalon_st_tx_ready
  );
endinterface

// File: rtl/avalon_st_gen.sv
// 10G Ethernet packet generator: sequence-numbered frames on a 64-bit Avalon-ST TX port.
// Define GEN_ERR_INJECT_EN to add periodic tx_error injection (CSR 0x0b/0x0c).
module avalon_st_gen #(
  parameter int unsigned IPG_CYCLES = 2,
  parameter int unsigned MIN_LEN    = 16,
  parameter int unsigned MAX_LEN    = 9600
) (
  input  logic            clk,
  input  logic            reset_n,
  avalon_st_gen_if.master bus,
  output logic            gen_active,
  output logic            gen_done
);

  localparam logic [13:0] MinLen  = 14'(MIN_LEN);
  localparam logic [13:0] MaxLen  = 14'(MAX_LEN);
  localparam bit          UseGap  = IPG_CYCLES > 1;
  localparam int unsigned GapLast = (IPG_CYCLES > 1) ? IPG_CYCLES - 2 : 0;

  typedef enum logic [2:0] {StIdle, StLoad, StSend, StGap, StDone} state_e;

  state_e      state_q, state_d;
  logic        acc_q;
  logic [31:0] num_pkt_q;
  logic [13:0] len_min_q, len_max_q;
  logic        done_q, stop_pend_q, first_q;
  logic [13:0] len_q;
  logic [10:0] words_q, beat_q;
  logic [31:0] gap_q;
  logic [31:0] seq_q, pkt_cnt_q;
  logic [63:0] byte_cnt_q;
  logic        err_flag;

  // CSR access: each strobe stalls exactly one cycle, then commits.
  logic mm_req, wait_req, wr_en, csr_wr, start_w, stop_w, start_ok;
  assign mm_req   = bus.avalon_mm_read | bus.avalon_mm_write;
  assign wait_req = mm_req & ~acc_q;
  assign wr_en    = bus.avalon_mm_write & ~wait_req;
  assign csr_wr   = wr_en && (bus.avalon_mm_address == 10'h007);
  assign start_w  = csr_wr & bus.avalon_mm_writedata[0];
  assign stop_w   = csr_wr & bus.avalon_mm_writedata[1];
  assign start_ok = start_w & ~stop_w & ((state_q == StIdle) | (state_q == StDone));

  function automatic logic [13:0] clamp_len(input logic [13:0] v);
    if (v < MinLen)      return MinLen;
    else if (v > MaxLen) return MaxLen;
    else                 return v;
  endfunction

  logic [13:0] lmin, lmax_c, lmax, len_inc, len_next;
  assign lmin     = clamp_len(len_min_q);
  assign lmax_c   = clamp_len(len_max_q);
  assign lmax     = (lmax_c < lmin) ? lmin : lmax_c;
  assign len_inc  = len_q + 14'd1;
  assign len_next = (first_q || len_q >= lmax || len_inc < lmin) ? lmin : len_inc;

  logic        tx_valid, accept, is_eop, eop_acc, stop_any, met_send, met_gap;
  logic [31:0] pkt_inc;
  assign tx_valid = (state_q == StSend);
  assign accept   = tx_valid & bus.avalon_st_tx_ready;
  assign is_eop   = (beat_q == words_q - 11'd1);
  assign eop_acc  = accept & is_eop;
  assign pkt_inc  = pkt_cnt_q + 32'd1;
  assign met_send = (num_pkt_q != '0) && (pkt_inc >= num_pkt_q);
  assign met_gap  = (num_pkt_q != '0) && (pkt_cnt_q >= num_pkt_q);
  assign stop_any = stop_pend_q | stop_w;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle, StDone: begin
        if (stop_w)       state_d = StDone;
        else if (start_w) state_d = StLoad;
      end
      StLoad: state_d = stop_any ? StDone : StSend;
      StSend: begin
        if (eop_acc) begin
          if (met_send || stop_any) state_d = StDone;
          else if (UseGap)          state_d = StGap;
          else                      state_d = StLoad;
        end
      end
      // LOAD is itself one idle cycle, so GAP covers the remaining IPG_CYCLES-1.
      StGap: begin
        if (stop_any || met_gap) state_d = StDone;
        else if (gap_q == GapLast) state_d = StLoad;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= StIdle;
    else          state_q <= state_d;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      acc_q       <= 1'b0;
      num_pkt_q   <= 32'd1;
      len_min_q   <= 14'd64;
      len_max_q   <= 14'd64;
      done_q      <= 1'b0;
      stop_pend_q <= 1'b0;
      first_q     <= 1'b1;
      len_q       <= '0;
      words_q     <= '0;
      beat_q      <= '0;
      gap_q       <= '0;
      seq_q       <= '0;
      pkt_cnt_q   <= '0;
      byte_cnt_q  <= '0;
    end else begin
      acc_q <= mm_req;
      if (wr_en) begin
        case (bus.avalon_mm_address)
          10'h000: num_pkt_q <= bus.avalon_mm_writedata;
          10'h001: len_min_q <= bus.avalon_mm_writedata[13:0];
          10'h002: len_max_q <= bus.avalon_mm_writedata[13:0];
          default: ;
        endcase
      end
      if (start_ok) begin
        pkt_cnt_q  <= '0;
        byte_cnt_q <= '0;
        seq_q      <= '0;
        first_q    <= 1'b1;
      end
      if (state_q == StLoad) begin
        len_q   <= len_next;
        words_q <= 11'((len_next + 14'd7) >> 3);
        beat_q  <= '0;
        first_q <= 1'b0;
      end
      if (accept) begin
        if (is_eop) begin
          beat_q     <= '0;
          pkt_cnt_q  <= pkt_inc;
          byte_cnt_q <= byte_cnt_q + {50'd0, len_q};
          seq_q      <= seq_q + 32'd1;
        end else begin
          beat_q <= beat_q + 11'd1;
        end
      end
      gap_q <= (state_q == StGap) ? gap_q + 32'd1 : '0;
      if (state_d == StDone) done_q <= 1'b1;
      else if (start_ok)     done_q <= 1'b0;
      if (state_d == StDone || start_ok)  stop_pend_q <= 1'b0;
      else if (state_q == StSend && stop_w) stop_pend_q <= 1'b1;
    end
  end

`ifdef GEN_ERR_INJECT_EN
  logic [15:0] err_period_q, err_phase_q;
  logic        err_flag_q;
  logic [31:0] err_cnt_q;

  // err_phase_q tracks seq mod err_period, so the flag marks (seq+1) % period == 0.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      err_period_q <= '0;
      err_phase_q  <= '0;
      err_flag_q   <= 1'b0;
      err_cnt_q    <= '0;
    end else begin
      if (wr_en && bus.avalon_mm_address == 10'h00b) err_period_q <= bus.avalon_mm_writedata[15:0];
      if (start_ok) begin
        err_phase_q <= '0;
        err_flag_q  <= 1'b0;
        err_cnt_q   <= '0;
      end else if (state_q == StLoad) begin
        if (err_period_q == '0) begin
          err_phase_q <= '0;
          err_flag_q  <= 1'b0;
        end else if ({1'b0, err_phase_q} + 17'd1 >= {1'b0, err_period_q}) begin
          err_phase_q <= '0;
          err_flag_q  <= 1'b1;
        end else begin
          err_phase_q <= err_phase_q + 16'd1;
          err_flag_q  <= 1'b0;
        end
      end
      if (eop_acc && err_flag_q) err_cnt_q <= err_cnt_q + 32'd1;
    end
  end
  assign err_flag = err_flag_q;
`else
  assign err_flag = 1'b0;
`endif

  logic [63:0] tx_data;
  always_comb begin
    tx_data = '0;
    if (tx_valid) begin
      if (beat_q == '0) begin
        tx_data = {16'hA5A5, 2'b00, len_q, seq_q};
      end else begin
        for (int i = 0; i < 8; i++) tx_data[63-8*i -: 8] = {beat_q[4:0], 3'(i)};
      end
    end
  end

  logic [31:0] rdata;
  always_comb begin
    rdata = '0;
    if (bus.avalon_mm_read) begin
      case (bus.avalon_mm_address)
        10'h000: rdata = num_pkt_q;
        10'h001: rdata = {18'd0, len_min_q};
        10'h002: rdata = {18'd0, len_max_q};
        10'h007: rdata = {28'd0, gen_active, done_q, 2'b00};
        10'h008: rdata = pkt_cnt_q;
        10'h009: rdata = byte_cnt_q[31:0];
        10'h00a: rdata = byte_cnt_q[63:32];
`ifdef GEN_ERR_INJECT_EN
        10'h00b: rdata = {16'd0, err_period_q};
        10'h00c: rdata = err_cnt_q;
`endif
        default: rdata = '0;
      endcase
    end
  end

  assign bus.avalon_mm_readdata    = rdata;
  assign bus.avalon_mm_waitrequest = wait_req;
  assign bus.avalon_st_tx_data     = tx_data;
  assign bus.avalon_st_tx_valid    = tx_valid;
  assign bus.avalon_st_tx_sop      = tx_valid & (beat_q == '0);
  assign bus.avalon_st_tx_eop      = tx_valid & is_eop;
  assign bus.avalon_st_tx_empty    = (tx_valid & is_eop) ? 3'(4'd8 - {1'b0, len_q[2:0]}) : 3'd0;
  assign bus.avalon_st_tx_error    = tx_valid & is_eop & err_flag;
  assign gen_active = (state_q != StIdle) && (state_q != StDone);
  assign gen_done   = done_q;

endmodule

// File: tb/tb_avalon_st_gen.sv
// Scoreboard bench for avalon_st_gen: a frame model fills an expected-beat queue,
// an independent monitor pops and compares every accepted beat.
module tb_avalon_st_gen;
  localparam int unsigned IPG = 2;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic gen_active, gen_done;

  avalon_st_gen_if bus();

  avalon_st_gen #(.IPG_CYCLES(IPG), .MIN_LEN(16), .MAX_LEN(9600)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .bus       (bus),
    .gen_active(gen_active),
    .gen_done  (gen_done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] data;
    logic        sop;
    logic        eop;
    logic [2:0]  empty;
    logic        err;
  } beat_t;

  beat_t       exp_q[$];
  int          tests = 0;
  int          fails = 0;
  int          sop_count = 0;
  int          eop_count = 0;
  int          run_id = 0;
  bit          mon_en = 1'b0;
  bit          rand_ready = 1'b0;
  longint      exp_bytes;
  int          exp_errs;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int clamp(input int v);
    if (v < 16)   return 16;
    if (v > 9600) return 9600;
    return v;
  endfunction

  // Reference frames straight from the length/layout rules.
  task automatic push_run(input int npkts, input int lmin_raw, input int lmax_raw,
                          input int period);
    int lmin, lmax, len, w;
    bit err;
    beat_t b;
    lmin = clamp(lmin_raw);
    lmax = clamp(lmax_raw);
    if (lmax < lmin) lmax = lmin;
    len = 0;
    exp_bytes = 0;
    exp_errs = 0;
    for (int p = 0; p < npkts; p++) begin
      len = (p == 0 || len >= lmax) ? lmin : len + 1;
      err = (period != 0) && (((p + 1) % period) == 0);
      if (err) exp_errs++;
      exp_bytes += len;
      w = (len + 7) / 8;
      for (int k = 0; k < w; k++) begin
        b.sop   = (k == 0);
        b.eop   = (k == w - 1);
        b.empty = b.eop ? 3'((8 - len % 8) % 8) : 3'd0;
        b.err   = b.eop & err;
        if (k == 0) begin
          b.data = {16'hA5A5, 16'(len), 32'(p)};
        end else begin
          for (int i = 0; i < 8; i++) b.data[63-8*i -: 8] = 8'((8 * k + i) % 256);
        end
        exp_q.push_back(b);
      end
    end
  endtask

  task automatic csr_access(input logic [9:0] addr, input bit wr, input logic [31:0] wdata,
                            output logic [31:0] rdata);
    @(posedge clk);
    #1;
    bus.avalon_mm_address   = addr;
    bus.avalon_mm_write     = wr;
    bus.avalon_mm_read      = !wr;
    bus.avalon_mm_writedata = wdata;
    @(negedge clk);
    check("waitreq_first_cycle", bus.avalon_mm_waitrequest, 1);
    @(negedge clk);
    check("waitreq_second_cycle", bus.avalon_mm_waitrequest, 0);
    rdata = bus.avalon_mm_readdata;
    @(posedge clk);
    #1;
    bus.avalon_mm_write = 1'b0;
    bus.avalon_mm_read  = 1'b0;
  endtask

  task automatic csr_wr(input logic [9:0] addr, input logic [31:0] data);
    logic [31:0] dummy;
    csr_access(addr, 1'b1, data, dummy);
  endtask

  task automatic csr_expect(input string name, input logic [9:0] addr, input logic [63:0] exp);
    logic [31:0] r;
    csr_access(addr, 1'b0, 32'd0, r);
    check(name, {32'd0, r}, exp);
  endtask

  task automatic run_start();
    run_id++;
    csr_wr(10'h007, 32'd1);
  endtask

  task automatic wait_done(input int budget);
    int n = 0;
    while (!gen_done && n < budget) begin
      @(negedge clk);
      n++;
    end
    check("done_within_budget", gen_done, 1);
  endtask

  task automatic config_run(input int np, input int lmin, input int lmax);
    csr_wr(10'h000, 32'(np));
    csr_wr(10'h001, 32'(lmin));
    csr_wr(10'h002, 32'(lmax));
  endtask

  // Sink ready: always high, or a 50% coin flip per cycle.
  initial begin
    bus.avalon_st_tx_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      bus.avalon_st_tx_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  // Monitor: scoreboard pops, stall stability, no mid-packet valid drop, inter-packet gap.
  initial begin
    bit          held_v;
    logic [68:0] held;
    bit          in_pkt;
    bit          gap_armed;
    int          idle;
    int          last_run;
    beat_t       e;
    held_v = 0; held = '0; in_pkt = 0; gap_armed = 0; idle = 0; last_run = 0;
    forever begin
      @(negedge clk);
      if (!mon_en) begin
        held_v = 0;
        in_pkt = 0;
        gap_armed = 0;
        continue;
      end
      if (run_id != last_run) begin
        last_run = run_id;
        gap_armed = 0;
      end
      if (held_v) begin
        check("stall_valid_held", bus.avalon_st_tx_valid, 1);
        check("stall_beat_stable", {bus.avalon_st_tx_data, bus.avalon_st_tx_sop,
              bus.avalon_st_tx_eop, bus.avalon_st_tx_empty}, held);
      end
      if (in_pkt) check("valid_in_packet", bus.avalon_st_tx_valid, 1);
      if (gap_armed) begin
        if (bus.avalon_st_tx_valid) begin
          check("ipg_idle_cycles", idle, (IPG > 0) ? IPG : 1);
          gap_armed = 0;
        end else begin
          idle++;
        end
      end
      if (bus.avalon_st_tx_valid && bus.avalon_st_tx_ready) begin
        check("beat_was_expected", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          check("beat_data", bus.avalon_st_tx_data, e.data);
          check("beat_sop_eop_empty_err", {bus.avalon_st_tx_sop, bus.avalon_st_tx_eop,
                bus.avalon_st_tx_empty, bus.avalon_st_tx_error},
                {e.sop, e.eop, e.empty, e.err});
        end
        if (bus.avalon_st_tx_sop) begin
          sop_count++;
          in_pkt = 1;
        end
        if (bus.avalon_st_tx_eop) begin
          eop_count++;
          in_pkt = 0;
          gap_armed = 1;
          idle = 0;
        end
      end
      held_v = bus.avalon_st_tx_valid && !bus.avalon_st_tx_ready;
      held = {bus.avalon_st_tx_data, bus.avalon_st_tx_sop, bus.avalon_st_tx_eop,
              bus.avalon_st_tx_empty};
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int snap;
    int n;
    bus.avalon_mm_address   = '0;
    bus.avalon_mm_write     = 1'b0;
    bus.avalon_mm_read      = 1'b0;
    bus.avalon_mm_writedata = '0;

    // Reset state
    #1;
    check("rst_tx_outputs", {bus.avalon_st_tx_data, bus.avalon_st_tx_valid, bus.avalon_st_tx_sop,
          bus.avalon_st_tx_eop, bus.avalon_st_tx_empty, bus.avalon_st_tx_error}, '0);
    check("rst_mm_outputs", {bus.avalon_mm_readdata, bus.avalon_mm_waitrequest}, '0);
    check("rst_status", {gen_active, gen_done}, 0);
    repeat (3) @(posedge clk);
    #2 reset_n = 1'b1;
    mon_en = 1'b1;
    csr_expect("rst_number_packet", 10'h000, 1);
    csr_expect("rst_len_min", 10'h001, 64);
    csr_expect("rst_len_max", 10'h002, 64);
    csr_expect("rst_csr", 10'h007, 0);
    csr_expect("rst_pkt_count", 10'h008, 0);
    csr_wr(10'h005, 32'hFFFF_FFFF);
    csr_expect("unmapped_reads_zero", 10'h005, 0);

    // Start and stop together: stop wins, done set, no frame
    run_id++;
    csr_wr(10'h007, 32'd3);
    repeat (10) @(negedge clk);
    check("start_stop_done", gen_done, 1);
    check("start_stop_no_sop", sop_count, 0);
    csr_expect("start_stop_csr", 10'h007, 4);

    // 3 x 64 bytes
    config_run(3, 64, 64);
    push_run(3, 64, 64, 0);
    run_start();
    wait_done(1000);
    check("t1_beats_outstanding", exp_q.size(), 0);
    csr_expect("t1_pkt_count", 10'h008, 3);
    csr_expect("t1_byte_lo", 10'h009, 64'(exp_bytes));
    csr_expect("t1_byte_hi", 10'h00a, 0);
    csr_expect("t1_csr_done", 10'h007, 4);

    // Length sweep 65..67 with wrap
    config_run(4, 65, 67);
    push_run(4, 65, 67, 0);
    run_start();
    wait_done(1000);
    check("t2_beats_outstanding", exp_q.size(), 0);
    csr_expect("t2_pkt_count", 10'h008, 4);
    csr_expect("t2_byte_lo", 10'h009, 64'(exp_bytes));

    // Random backpressure, 2 x 100 bytes
    config_run(2, 100, 100);
    push_run(2, 100, 100, 0);
    rand_ready = 1'b1;
    run_start();
    wait_done(2000);
    rand_ready = 1'b0;
    check("t3_beats_outstanding", exp_q.size(), 0);
    csr_expect("t3_byte_lo", 10'h009, 64'(exp_bytes));

    // Continuous run; start while busy is ignored; stop mid-packet
    config_run(0, 200, 200);
    push_run(40, 200, 200, 0);
    snap = sop_count;
    run_start();
    n = 0;
    while (sop_count < snap + 2 && n < 500) begin
      @(negedge clk);
      n++;
    end
    check("t4_second_sop_seen", sop_count >= snap + 2, 1);
    csr_wr(10'h007, 32'd1);
    csr_wr(10'h007, 32'd2);
    snap = sop_count;
    wait_done(500);
    repeat (10) @(negedge clk);
    check("t4_no_sop_after_stop", sop_count, snap);
    check("t4_no_truncated_frame", eop_count, sop_count);
    csr_expect("t4_csr_done", 10'h007, 4);
    exp_q.delete();

    // Lengths below the hard minimum clamp to 16
    config_run(1, 8, 4);
    push_run(1, 8, 4, 0);
    run_start();
    wait_done(500);
    check("t5_beats_outstanding", exp_q.size(), 0);
    csr_expect("t5_byte_lo", 10'h009, 64'(exp_bytes));

`ifdef GEN_ERR_INJECT_EN
    csr_wr(10'h00b, 32'd2);
    csr_expect("err_period_rw", 10'h00b, 2);
    config_run(4, 64, 64);
    push_run(4, 64, 64, 2);
    run_start();
    wait_done(1000);
    check("err_beats_outstanding", exp_q.size(), 0);
    csr_expect("err_count", 10'h00c, exp_errs);
`else
    csr_wr(10'h00b, 32'd2);
    csr_expect("no_err_period_reg", 10'h00b, 0);
    csr_expect("no_err_count_reg", 10'h00c, 0);
`endif

    // Asynchronous reset mid-packet
    config_run(2, 200, 200);
    mon_en = 1'b0;
    exp_q.delete();
    run_start();
    n = 0;
    while (!bus.avalon_st_tx_valid && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("rst_test_packet_started", bus.avalon_st_tx_valid, 1);
    repeat (3) @(posedge clk);
    #3 reset_n = 1'b0;
    #1;
    check("async_rst_tx_outputs", {bus.avalon_st_tx_data, bus.avalon_st_tx_valid,
          bus.avalon_st_tx_sop, bus.avalon_st_tx_eop, bus.avalon_st_tx_empty,
          bus.avalon_st_tx_error}, '0);
    check("async_rst_status", {gen_active, gen_done}, 0);
    @(posedge clk);
    #2 reset_n = 1'b1;
    @(negedge clk);
    check("post_rst_idle", bus.avalon_st_tx_valid, 0);
    csr_expect("post_rst_number_packet", 10'h000, 1);
    csr_expect("post_rst_pkt_count", 10'h008, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
